// File: rtl/load_store_unit.sv
// load_store_unit: data-memory load/store unit for the pipelined RISC-V core.
// Holds a word-organised little-endian array (mem) and serves one request at
// a time over a valid/ready handshake with a configurable access latency.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   req_valid   request present
//   req_ready   unit idle and able to accept a request
//   req_we      1 = store, 0 = load
//   req_funct3  RISC-V funct3 selecting size and extension
//   req_addr    byte address
//   req_wdata   store data, right-aligned
//   resp_valid  one-cycle response pulse
//   resp_rdata  extended load data (0 for stores and faults), held between pulses
//   resp_err    access fault, qualified by resp_valid
//   busy        request in flight
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            busy
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // WAIT lasts LATENCY-1 cycles; the counter starts at 0 on entry.
  localparam logic [3:0] WAIT_LAST = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic            r_we;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;

  logic [XLEN-1:0] mem [DEPTH];

  // The array is accessed on the edge entering RESP. With LATENCY=1 that is
  // the acceptance edge itself, so the live request fields are used directly;
  // otherwise the captured copy is used.
  logic            a_we;
  logic [2:0]      a_f3;
  logic [XLEN-1:0] a_addr;
  logic [XLEN-1:0] a_wdata;
  logic            fire;

  always_comb begin
    if (state == IDLE) begin
      a_we    = req_we;
      a_f3    = req_funct3;
      a_addr  = req_addr;
      a_wdata = req_wdata;
    end else begin
      a_we    = r_we;
      a_f3    = r_f3;
      a_addr  = r_addr;
      a_wdata = r_wdata;
    end
    if (LATENCY == 1) fire = (state == IDLE) && req_valid;
    else              fire = (state == WAIT) && (cnt == WAIT_LAST);
  end

  logic [XLEN-1:0] widx;
  logic [OFFW-1:0] off;
  logic [AW-1:0]   idx;
  logic            legal;
  logic            misal;
  logic            oor;
  logic            err;
  logic [XLEN-1:0] rword;
  logic [XLEN-1:0] rsh;
  logic [XLEN-1:0] rdata_n;
  logic [NB-1:0]   bmask;
  logic [XLEN-1:0] wsh;

  always_comb begin
    widx = a_addr >> OFFW;
    off  = a_addr[OFFW-1:0];
    idx  = widx[AW-1:0];
    oor  = (widx >= XLEN'(DEPTH));

    case (a_f3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b011:                 legal = (XLEN == 64);
      3'b100, 3'b101:         legal = !a_we;
      3'b110:                 legal = !a_we && (XLEN == 64);
      default:                legal = 1'b0;
    endcase

    case (a_f3[1:0])
      2'b00:   misal = 1'b0;
      2'b01:   misal = a_addr[0];
      2'b10:   misal = |a_addr[1:0];
      default: misal = |a_addr[2:0];
    endcase

    err = !legal || misal || oor;

    // Loads: shift the addressed lane down to bit 0, then extend.
    rword = mem[idx];
    rsh   = rword >> {off, 3'b000};
    case (a_f3)
      3'b000:  rdata_n = XLEN'($signed(rsh[7:0]));
      3'b001:  rdata_n = XLEN'($signed(rsh[15:0]));
      3'b010:  rdata_n = XLEN'($signed(rsh[31:0]));
      3'b100:  rdata_n = XLEN'(rsh[7:0]);
      3'b101:  rdata_n = XLEN'(rsh[15:0]);
      3'b110:  rdata_n = XLEN'(rsh[31:0]);
      default: rdata_n = rsh;
    endcase

    // Stores: byte-enable mask and data moved up to the addressed lane.
    case (a_f3[1:0])
      2'b00:   bmask = NB'(8'h01);
      2'b01:   bmask = NB'(8'h03);
      2'b10:   bmask = NB'(8'h0F);
      default: bmask = NB'(8'hFF);
    endcase
    bmask = bmask << off;
    wsh   = a_wdata << {off, 3'b000};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      r_we       <= 1'b0;
      r_f3       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_f3    <= req_funct3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            cnt     <= '0;
            state   <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == WAIT_LAST) state <= RESP;
          else                  cnt   <= cnt + 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (fire) begin
        resp_err   <= err;
        resp_rdata <= (err || a_we) ? '0 : rdata_n;
      end
    end
  end

  // No reset on the array; the rst term keeps a store from landing while
  // reset is held.
  always_ff @(posedge clk) begin
    if (rst && fire && !err && a_we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (bmask[b]) mem[idx][8*b +: 8] <= wsh[8*b +: 8];
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: self-checking bench for load_store_unit.
// Three instances (XLEN/LATENCY/DEPTH = 32/1/64, 32/4/64, 64/2/32) share a
// clock. A byte-addressed reference memory predicts every response; the
// stimulus process queues expectations and a negedge monitor checks each
// response, its latency and the ready/busy flags.
module tb_load_store_unit;

  localparam int NC  = 3;
  localparam int XL0 = 32, LT0 = 1, DP0 = 64;
  localparam int XL1 = 32, LT1 = 4, DP1 = 64;
  localparam int XL2 = 64, LT2 = 2, DP2 = 32;
  localparam int XLS [NC] = '{XL0, XL1, XL2};
  localparam int LATS[NC] = '{LT0, LT1, LT2};
  localparam int DEPS[NC] = '{DP0, DP1, DP2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0] rst, rv, rwe, rdy, vld, err, bsy;
  logic [2:0]    rf3   [NC];
  logic [63:0]   raddr [NC];
  logic [63:0]   rwd   [NC];
  logic [31:0]   rd0, rd1;
  logic [63:0]   rd2;

  load_store_unit #(.XLEN(XL0), .DEPTH(DP0), .LATENCY(LT0)) u0 (
    .clk(clk), .rst(rst[0]), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(rwe[0]),
    .req_funct3(rf3[0]), .req_addr(raddr[0][31:0]), .req_wdata(rwd[0][31:0]),
    .resp_valid(vld[0]), .resp_rdata(rd0), .resp_err(err[0]), .busy(bsy[0]));

  load_store_unit #(.XLEN(XL1), .DEPTH(DP1), .LATENCY(LT1)) u1 (
    .clk(clk), .rst(rst[1]), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(rwe[1]),
    .req_funct3(rf3[1]), .req_addr(raddr[1][31:0]), .req_wdata(rwd[1][31:0]),
    .resp_valid(vld[1]), .resp_rdata(rd1), .resp_err(err[1]), .busy(bsy[1]));

  load_store_unit #(.XLEN(XL2), .DEPTH(DP2), .LATENCY(LT2)) u2 (
    .clk(clk), .rst(rst[2]), .req_valid(rv[2]), .req_ready(rdy[2]), .req_we(rwe[2]),
    .req_funct3(rf3[2]), .req_addr(raddr[2]), .req_wdata(rwd[2]),
    .resp_valid(vld[2]), .resp_rdata(rd2), .resp_err(err[2]), .busy(bsy[2]));

  int nrun  = 0;
  int nfail = 0;
  int cyc   = 0;

  logic [64:0] expq [NC][$];   // {err, rdata}
  int          accq [NC][$];   // edge number at which each request was accepted
  logic [7:0]  bm   [NC][256]; // reference memory, byte addressed

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [64:0] act, logic [64:0] exp);
    nrun++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rdv(int c);
    case (c)
      0:       return {32'b0, rd0};
      1:       return {32'b0, rd1};
      default: return rd2;
    endcase
  endfunction

  function automatic logic [63:0] bmword(int c, int w);
    logic [63:0] v = '0;
    int nb = XLS[c] / 8;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = bm[c][w*nb + i];
    return v;
  endfunction

  task automatic setw(int c, int w, logic [63:0] v);
    int nb = XLS[c] / 8;
    for (int i = 0; i < nb; i++) bm[c][w*nb + i] = v[8*i +: 8];
  endtask

  // Reference behaviour straight from the access rules: size from funct3,
  // legality table, alignment by modulo, range by division, byte-wise copy.
  task automatic model(int c, logic we, logic [2:0] f3, logic [63:0] a, logic [63:0] wd,
                       output logic e, output logic [63:0] rd);
    int xl = XLS[c];
    int nb = xl / 8;
    int sz = 1 << f3[1:0];
    bit legal;
    logic [63:0] v;
    if (we) legal = (f3 <= 3'd2) || (f3 == 3'd3 && xl == 64);
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (xl == 64 && f3 inside {3'd3, 3'd6});
    e  = !legal || (a % sz != 0) || (a / nb >= 64'(DEPS[c]));
    rd = '0;
    if (!e) begin
      if (we) begin
        for (int i = 0; i < sz; i++) bm[c][int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = bm[c][int'(a) + i];
        if (!f3[2] && sz < 8 && v[sz*8-1]) begin
          for (int b = sz*8; b < 64; b++) v[b] = 1'b1;
        end
        rd = (xl == 32) ? {32'b0, v[31:0]} : v;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < NC; c++) begin
      int k;
      if (!rst[c]) begin
        accq[c].delete();
        expq[c].delete();
      end
      chk($sformatf("ready[%0d]@%0d", c, cyc), 65'(rdy[c]), 65'(accq[c].size() == 0));
      chk($sformatf("busy[%0d]@%0d", c, cyc), 65'(bsy[c]), 65'(accq[c].size() != 0));
      if (vld[c]) begin
        if (accq[c].size() == 0) begin
          nrun++; nfail++;
          $display("FAIL spurious_resp[%0d]: got resp_valid at cycle %0d want none", c, cyc);
        end else begin
          k = accq[c].pop_front();
          chk($sformatf("latency[%0d]", c), 65'(cyc), 65'(k + LATS[c] - 1));
          if (expq[c].size() == 0) begin
            nrun++; nfail++;
            $display("FAIL resp_unexpected[%0d]: got %h want no response", c, {err[c], rdv(c)});
          end else begin
            chk($sformatf("resp[%0d]@%0d", c, cyc), {err[c], rdv(c)}, expq[c].pop_front());
          end
        end
      end else if (accq[c].size() != 0 && cyc > accq[c][0] + LATS[c] - 1) begin
        nrun++; nfail++;
        $display("FAIL resp_timeout[%0d]: got none want response at cycle %0d", c, accq[c][0] + LATS[c] - 1);
        void'(accq[c].pop_front());
        if (expq[c].size() != 0) void'(expq[c].pop_front());
      end
      if (rv[c] && rdy[c] && rst[c]) accq[c].push_back(cyc + 1);
    end
  end

  task automatic issue(int c, logic we, logic [2:0] f3, logic [63:0] a, logic [63:0] wd,
                       bit directed, logic e_err, logic [63:0] e_rd, bit hold, output int acc);
    logic m_err;
    logic [63:0] m_rd;
    int n = 0;
    rwe[c] = we; rf3[c] = f3; raddr[c] = a; rwd[c] = wd; rv[c] = 1'b1;
    model(c, we, f3, a, wd, m_err, m_rd);
    expq[c].push_back(directed ? {e_err, e_rd} : {m_err, m_rd});
    acc = -1;
    forever begin
      @(negedge clk);
      if (rdy[c]) begin
        acc = cyc + 1;
        break;
      end
      n++;
      if (n > 50) begin
        nrun++; nfail++;
        $display("FAIL accept_timeout[%0d]: got req_ready=0 want 1 within 50 cycles", c);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!hold) rv[c] = 1'b0;
  endtask

  task automatic dir(int c, logic we, logic [2:0] f3, logic [63:0] a, logic [63:0] wd,
                     logic e, logic [63:0] r);
    int acc;
    issue(c, we, f3, a, wd, 1'b1, e, r, 1'b0, acc);
  endtask

  task automatic rand_run(int c, int n);
    int nb = XLS[c] / 8;
    int acc, w, sz, off;
    logic we;
    logic [2:0] f3;
    for (int i = 0; i < n; i++) begin
      we  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      sz  = 1 << f3[1:0];
      w   = int'($urandom_range(0, DEPS[c]));
      off = int'($urandom_range(0, nb - 1));
      if ($urandom_range(0, 3) != 0) off = off & ~(sz - 1);
      issue(c, we, f3, 64'(w*nb + off), {$urandom, $urandom}, 1'b0, 1'b0, '0, 1'b0, acc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int a1, a2, a3, n;
    logic [63:0] v;
    rst = '0; rv = '0; rwe = '0;
    for (int c = 0; c < NC; c++) begin
      rf3[c] = '0; raddr[c] = '0; rwd[c] = '0;
    end
    for (int w = 0; w < DP0; w++) begin v = {$urandom, $urandom}; u0.mem[w] = v[31:0]; setw(0, w, v); end
    for (int w = 0; w < DP1; w++) begin v = {$urandom, $urandom}; u1.mem[w] = v[31:0]; setw(1, w, v); end
    for (int w = 0; w < DP2; w++) begin v = {$urandom, $urandom}; u2.mem[w] = v;       setw(2, w, v); end
    u0.mem[0] = 32'h12345678; setw(0, 0, 64'h12345678);
    u0.mem[1] = 32'h9ABCDEF0; setw(0, 1, 64'h9ABCDEF0);
    u0.mem[2] = 32'h11223344; setw(0, 2, 64'h11223344);
    u0.mem[4] = 32'h99AABBCC; setw(0, 4, 64'h99AABBCC);
    u0.mem[5] = 32'hDDEEFF00; setw(0, 5, 64'hDDEEFF00);
    u1.mem[0] = 32'hCAFEF00D; setw(1, 0, 64'hCAFEF00D);
    u1.mem[1] = 32'h0BADBEEF; setw(1, 1, 64'h0BADBEEF);
    u1.mem[2] = 32'h55555555; setw(1, 2, 64'h55555555);
    u2.mem[0] = 64'h8877665544332211; setw(2, 0, 64'h8877665544332211);

    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("rst_valid[%0d]", c), 65'(vld[c]), 65'(0));
      chk($sformatf("rst_resp[%0d]", c), {err[c], rdv(c)}, 65'(0));
    end
    @(posedge clk); #1;
    rst = '1;

    // XLEN=32, LATENCY=1: loads
    dir(0, 0, 3'b010, 0,  0, 0, 64'h12345678);
    dir(0, 0, 3'b001, 4,  0, 0, 64'hFFFFDEF0);
    dir(0, 0, 3'b101, 4,  0, 0, 64'h0000DEF0);
    dir(0, 0, 3'b000, 8,  0, 0, 64'h00000044);
    dir(0, 0, 3'b000, 11, 0, 0, 64'h00000011);
    // stores, then read back
    dir(0, 1, 3'b001, 18, 64'h0000BEEF, 0, 0);
    dir(0, 1, 3'b000, 20, 64'hFFFFFF44, 0, 0);
    dir(0, 1, 3'b010, 12, 64'h12345678, 0, 0);
    dir(0, 0, 3'b010, 16, 0, 0, 64'hBEEFBBCC);
    dir(0, 0, 3'b010, 20, 0, 0, 64'hDDEEFF44);
    dir(0, 0, 3'b010, 12, 0, 0, 64'h12345678);
    // faults
    dir(0, 0, 3'b010, 2,     0, 1, 0);
    dir(0, 0, 3'b001, 5,     0, 1, 0);
    dir(0, 0, 3'b010, 4*DP0, 0, 1, 0);
    dir(0, 0, 3'b011, 0,     0, 1, 0);
    dir(0, 0, 3'b110, 0,     0, 1, 0);
    dir(0, 1, 3'b010, 2,     64'hDEADBEEF, 1, 0);
    dir(0, 1, 3'b100, 0,     64'hDEADBEEF, 1, 0);
    dir(0, 1, 3'b011, 0,     64'hDEADBEEF, 1, 0);
    dir(0, 1, 3'b001, 4*DP0, 64'hDEADBEEF, 1, 0);
    dir(0, 0, 3'b010, 0, 0, 0, 64'h12345678);

    // LATENCY=4: back-to-back with req_valid held
    issue(1, 0, 3'b010, 0, 0, 1'b1, 0, 64'hCAFEF00D, 1'b1, a1);
    issue(1, 0, 3'b010, 4, 0, 1'b1, 0, 64'h0BADBEEF, 1'b1, a2);
    issue(1, 0, 3'b000, 3, 0, 1'b1, 0, 64'hFFFFFFCA, 1'b0, a3);
    chk("spacing12", 65'(a2 - a1), 65'(LT1 + 1));
    chk("spacing23", 65'(a3 - a2), 65'(LT1 + 1));

    // LATENCY=4: store aborted by reset two cycles after acceptance
    rwe[1] = 1'b1; rf3[1] = 3'b010; raddr[1] = 64'd8; rwd[1] = 64'hFFFFFFFF; rv[1] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[1] && n < 50);
    @(posedge clk); #1;
    rv[1] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst[1] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst[1] = 1'b1;
    dir(1, 0, 3'b010, 8, 0, 0, 64'h55555555);

    // XLEN=64, LATENCY=2
    dir(2, 0, 3'b011, 0, 0, 0, 64'h8877665544332211);
    dir(2, 0, 3'b010, 4, 0, 0, 64'hFFFFFFFF88776655);
    dir(2, 0, 3'b110, 4, 0, 0, 64'h0000000088776655);
    dir(2, 0, 3'b001, 6, 0, 0, 64'hFFFFFFFFFFFF8877);
    dir(2, 1, 3'b011, 8, 64'h0123456789ABCDEF, 0, 0);
    dir(2, 0, 3'b011, 8, 0, 0, 64'h0123456789ABCDEF);
    dir(2, 0, 3'b011, 4, 0, 1, 0);
    dir(2, 0, 3'b111, 0, 0, 1, 0);

    for (int c = 0; c < NC; c++) rand_run(c, 80);

    repeat (20) @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("drain_acc[%0d]", c), 65'(accq[c].size()), 65'(0));
      chk($sformatf("drain_exp[%0d]", c), 65'(expq[c].size()), 65'(0));
    end
    for (int w = 0; w < DP0; w++) chk($sformatf("mem0[%0d]", w), 65'(u0.mem[w]), 65'(bmword(0, w)));
    for (int w = 0; w < DP1; w++) chk($sformatf("mem1[%0d]", w), 65'(u1.mem[w]), 65'(bmword(1, w)));
    for (int w = 0; w < DP2; w++) chk($sformatf("mem2[%0d]", w), 65'(u2.mem[w]), 65'(bmword(2, w)));

    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
